fetch_queue: RTL and testbench

Instruction buffer directly downstream of the fetch unit. Captures each fetched {pc, instr} pair on a valid/ready handshake and presents them in order to the decode stage, decoupling fetch from decode stalls. Tags each entry with an address-error flag. Supports a single-cycle flush for branch/jump redirects.

---
 rtl/fetch_queue.sv | 79 +++++++
 tb/tb_fetch_queue.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order {pc, instr, adel} buffer between fetch and decode
// Circular buffer with an extra pointer MSB to tell full from empty; flush empties in one cycle.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] PC_BASE  = 32'h0000_3000,
    parameter logic [31:0] PC_LIMIT = 32'h0000_6FFF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_pc,
    input  logic [31:0]            in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_instr,
    output logic                   out_adel,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [31:0]   mem_pc    [DEPTH];
    logic [31:0]   mem_instr [DEPTH];
    logic [DEPTH-1:0] mem_adel;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic adel;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign count = wptr - rptr;

    // in_ready depends only on registered state (and reset), never on out_ready/in_valid
    assign in_ready  = reset && !full;
    assign out_valid = !empty;

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    assign adel = (in_pc[1:0] != 2'b00) || (in_pc < PC_BASE) || (in_pc > PC_LIMIT);

    // Outputs are gated by empty so stale storage after a flush is never visible
    assign out_pc    = empty ? 32'h0 : mem_pc[rptr[AW-1:0]];
    assign out_instr = empty ? 32'h0 : mem_instr[rptr[AW-1:0]];
    assign out_adel  = empty ? 1'b0  : mem_adel[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            mem_adel <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]    <= '0;
                mem_instr[i] <= '0;
            end
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                mem_pc[wptr[AW-1:0]]    <= in_pc;
                mem_instr[wptr[AW-1:0]] <= in_instr;
                mem_adel[wptr[AW-1:0]]  <= adel;
                wptr                    <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed and random checks of fetch_queue against a queue model
// Model is a SystemVerilog queue of entries; outputs are compared on every falling edge.
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_adel;
    logic        flush;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } ent_t;
    ent_t q[$];

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_adel(out_adel),
        .flush(flush), .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic bad_addr(logic [31:0] pc);
        return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFF);
    endfunction

    // Reference model: occupancy-limited queue, evaluated at each rising edge
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            automatic bit can_push = q.size() < DEPTH;
            automatic bit can_pop  = q.size() > 0;
            if (can_pop && out_ready) void'(q.pop_front());
            if (can_push && in_valid) begin
                automatic ent_t e;
                e.pc    = in_pc;
                e.instr = in_instr;
                e.adel  = bad_addr(in_pc);
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        automatic bit ne = q.size() > 0;
        chk("out_valid", 32'(out_valid), 32'(ne));
        chk("count", 32'(count), 32'(q.size()));
        chk("in_ready", 32'(in_ready), 32'(reset && q.size() < DEPTH));
        chk("out_pc", out_pc, ne ? q[0].pc : 32'h0);
        chk("out_instr", out_instr, ne ? q[0].instr : 32'h0);
        chk("out_adel", 32'(out_adel), ne ? 32'(q[0].adel) : 32'h0);
    end

    task automatic cyc(logic v, logic [31:0] pc, logic [31:0] ins, logic ordy, logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] pcs [4];
        reset = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("reset out_valid", 32'(out_valid), 32'h0);
        chk("reset count", 32'(count), 32'h0);
        chk("reset in_ready", 32'(in_ready), 32'h1);
        chk("reset out_pc", out_pc, 32'h0);
        chk("reset out_instr", out_instr, 32'h0);

        // Fill to full, reject a fifth push, then drain in order
        for (int k = 0; k < 4; k++) cyc(1, 32'h3000 + 4 * k, 32'h11111111 * (k + 1), 0, 0);
        chk("fill count", 32'(count), 32'h4);
        chk("fill in_ready", 32'(in_ready), 32'h0);
        cyc(1, 32'h3010, 32'h55555555, 1, 0);
        chk("full push rejected count", 32'(count), 32'h3);
        chk("drain pc1", out_pc, 32'h3004);
        for (int k = 1; k < 4; k++) begin
            chk("drain pc", out_pc, 32'h3000 + 4 * k);
            chk("drain instr", out_instr, 32'h11111111 * (k + 1));
            cyc(0, 0, 0, 1, 0);
        end
        chk("drained count", 32'(count), 32'h0);

        // Streaming push+pop with pointer wrap
        for (int i = 0; i < 10; i++) begin
            cyc(1, 32'h3000 + 4 * i, 32'hA000_0000 + i, 1, 0);
            chk("stream pc", out_pc, 32'h3000 + 4 * i);
            chk("stream count", 32'(count), 32'h1);
        end
        cyc(0, 0, 0, 1, 0);

        // Address error flags
        pcs[0] = 32'h3002; pcs[1] = 32'h2FFC; pcs[2] = 32'h7000; pcs[3] = 32'h6FFC;
        for (int k = 0; k < 4; k++) cyc(1, pcs[k], 32'hC0DE_0000 + k, 0, 0);
        for (int k = 0; k < 4; k++) begin
            chk("adel pc", out_pc, pcs[k]);
            chk("adel flag", 32'(out_adel), (k < 3) ? 32'h1 : 32'h0);
            chk("adel instr", out_instr, 32'hC0DE_0000 + k);
            cyc(0, 0, 0, 1, 0);
        end

        // Flush with same-cycle push and pop
        for (int k = 0; k < 3; k++) cyc(1, 32'h3100 + 4 * k, k, 0, 0);
        cyc(1, 32'h3200, 32'hDEAD_BEEF, 1, 1);
        chk("flush count", 32'(count), 32'h0);
        chk("flush out_valid", 32'(out_valid), 32'h0);
        cyc(1, 32'h3400, 32'h1234_5678, 0, 0);
        chk("post-flush pc", out_pc, 32'h3400);
        chk("post-flush instr", out_instr, 32'h1234_5678);
        cyc(0, 0, 0, 1, 0);

        // Asynchronous reset between edges
        cyc(1, 32'h3300, 1, 0, 0);
        cyc(1, 32'h3304, 2, 0, 0);
        in_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async out_valid", 32'(out_valid), 32'h0);
        chk("async count", 32'(count), 32'h0);
        chk("async in_ready", 32'(in_ready), 32'h0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        cyc(1, 32'h3500, 32'h0BAD_F00D, 0, 0);
        chk("post-reset pc", out_pc, 32'h3500);
        chk("post-reset count", 32'(count), 32'h1);
        cyc(0, 0, 0, 1, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] pc;
            case ($urandom_range(0, 3))
                0: pc = 32'h3000 + {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
                1: pc = 32'h3000 + {18'h0, 12'($urandom_range(0, 4095)), 2'b00} + $urandom_range(1, 3);
                2: pc = $urandom;
                default: begin
                    case ($urandom_range(0, 3))
                        0: pc = 32'h2FFC;
                        1: pc = 32'h3000;
                        2: pc = 32'h6FFC;
                        default: pc = 32'h7000;
                    endcase
                end
            endcase
            cyc(1'($urandom_range(0, 1)), pc, $urandom, 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 15) == 0));
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
